// File: rtl/fp_unpack.sv
// Unpacks a raw binary32 operand into the 33-bit monotonic extended form and
// the one-hot fclass vector; subnormals are normalized one bit per cycle.
module fp_unpack (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [32:0] out_ext,
    output logic [9:0]  out_class
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_data;
    logic [32:0] r_ext;
    logic [9:0]  r_class;
    logic [22:0] r_mant;
    logic [4:0]  r_lz;

    logic        w_sign;
    logic [7:0]  w_exp;
    logic [22:0] w_man;
    logic        w_accept;
    logic        w_isSub;
    logic [32:0] w_fastExt;
    logic [9:0]  w_fastClass;
    logic [32:0] w_normExt;
    logic [9:0]  w_normClass;

    assign w_sign   = in_data[31];
    assign w_exp    = in_data[30:23];
    assign w_man    = in_data[22:0];
    assign w_accept = in_valid && (r_state == IDLE);
    assign w_isSub  = (w_exp == 8'd0) && (w_man != 23'd0);

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_data  = r_data;
    assign out_ext   = r_ext;
    assign out_class = r_class;

    // Normalized subnormal: once the leading one reaches bit 22 it becomes the hidden bit.
    assign w_normExt   = {r_data[31], 9'd129 - {4'd0, r_lz}, r_mant[21:0], 1'b0};
    assign w_normClass = r_data[31] ? 10'h004 : 10'h020;

    always_comb begin
        w_nextState = r_state;
        w_fastExt   = '0;
        w_fastClass = '0;
        if (w_exp == 8'hFF) begin
            w_fastExt = {w_sign, 9'h1C0, w_man};
            if (w_man == 23'd0)
                w_fastClass = w_sign ? 10'h001 : 10'h080;
            else
                w_fastClass = w_man[22] ? 10'h200 : 10'h100;
        end else if (w_exp == 8'd0) begin
            w_fastExt   = {w_sign, 32'd0};
            w_fastClass = w_sign ? 10'h008 : 10'h010;
        end else begin
            w_fastExt   = {w_sign, {1'b0, w_exp} + 9'd129, w_man};
            w_fastClass = w_sign ? 10'h002 : 10'h040;
        end

        case (r_state)
            IDLE: if (w_accept) w_nextState = w_isSub ? NORM : DONE;
            NORM: if (r_mant[22]) w_nextState = DONE;
            DONE: if (out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    // Results are written only on accept or normalization finish, so DONE holds them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_data  <= '0;
            r_ext   <= '0;
            r_class <= '0;
            r_mant  <= '0;
            r_lz    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_data <= in_data;
                        if (w_isSub) begin
                            r_mant <= w_man;
                            r_lz   <= 5'd0;
                        end else begin
                            r_ext   <= w_fastExt;
                            r_class <= w_fastClass;
                        end
                    end
                end
                NORM: begin
                    if (r_mant[22]) begin
                        r_ext   <= w_normExt;
                        r_class <= w_normClass;
                    end else begin
                        r_mant <= r_mant << 1;
                        r_lz   <= r_lz + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_unpack.sv
// Self-checking bench for fp_unpack: directed corner operands, backpressure,
// asynchronous reset mid-normalization, and a randomized sweep against a reference model.
module tb_fp_unpack;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [32:0] out_ext;
    logic [9:0]  out_class;

    int nAsserts = 0;
    int nFail    = 0;

    fp_unpack dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ext   (out_ext),
        .out_class (out_class)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout observed no finish expected finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    task automatic checkOutput(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model derived from value categories and plain arithmetic.
    function automatic void refModel(input logic [31:0] d, output logic [32:0] ext,
                                     output logic [9:0] cls, output int lat);
        int  e, m, e9, frac, lz;
        logic s;
        s    = d[31];
        e    = int'(d[30:23]);
        m    = int'(d[22:0]);
        lat  = 1;
        cls  = '0;
        e9   = 0;
        frac = 0;
        if (e == 255) begin
            e9   = 448;
            frac = m;
            if (m == 0)            cls = s ? 10'd1 : 10'd128;
            else if (m >= 4194304) cls = 10'd512;
            else                   cls = 10'd256;
        end else if (e == 0 && m == 0) begin
            cls = s ? 10'd8 : 10'd16;
        end else if (e == 0) begin
            lz = 0;
            while (m * (2 ** lz) < 4194304) lz++;
            e9   = 129 - lz;
            frac = (m * (2 ** (lz + 1))) % 8388608;
            cls  = s ? 10'd4 : 10'd32;
            lat  = lz + 2;
        end else begin
            e9   = e + 129;
            frac = m;
            cls  = s ? 10'd2 : 10'd64;
        end
        ext = {s, 9'(e9), 23'(frac)};
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic applyStimulus(input logic [31:0] d, input int stall, input logic decoy,
                                 output logic [32:0] extSeen);
        logic [32:0] eExt;
        logic [9:0]  eCls;
        int          eLat;
        int          lat;
        refModel(d, eExt, eCls, eLat);
        checkOutput("in_ready_idle", 33'(in_ready), 33'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clock);
        in_valid = 1'b0;
        in_data  = $urandom;
        lat      = 1;
        while (!out_valid && lat < 40) begin
            checkOutput("in_ready_busy", 33'(in_ready), 33'd0);
            @(negedge clock);
            in_data = $urandom;
            lat++;
        end
        checkOutput("out_valid", 33'(out_valid), 33'd1);
        checkOutput("latency", 33'(lat), 33'(eLat));
        checkOutput("out_data", 33'(out_data), 33'(d));
        checkOutput("out_ext", out_ext, eExt);
        checkOutput("out_class", 33'(out_class), 33'(eCls));
        checkOutput("in_ready_done", 33'(in_ready), 33'd0);
        extSeen = out_ext;
        for (int i = 0; i < stall; i++) begin
            if (decoy) begin
                in_valid = 1'b1;
                in_data  = 32'h40490FDB;
            end
            @(negedge clock);
            checkOutput("hold_valid", 33'(out_valid), 33'd1);
            checkOutput("hold_ready", 33'(in_ready), 33'd0);
            checkOutput("hold_data", 33'(out_data), 33'(d));
            checkOutput("hold_ext", out_ext, eExt);
            checkOutput("hold_class", 33'(out_class), 33'(eCls));
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput("in_ready_after", 33'(in_ready), 33'd1);
        checkOutput("out_valid_after", 33'(out_valid), 33'd0);
    endtask

    initial begin
        logic [32:0] extTmp, extSubA, extSubB, extMin;
        logic [31:0] d;
        logic [22:0] m;
        int          cat;

        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        #1;
        checkOutput("rst_in_ready", 33'(in_ready), 33'd1);
        checkOutput("rst_out_valid", 33'(out_valid), 33'd0);
        checkOutput("rst_out_data", 33'(out_data), 33'd0);
        checkOutput("rst_out_ext", out_ext, 33'd0);
        checkOutput("rst_out_class", 33'(out_class), 33'd0);
        @(negedge clock);
        reset = 1'b1;

        applyStimulus(32'h3F800000, 0, 1'b0, extTmp);
        checkOutput("one_ext_const", extTmp, 33'h0_8000_0000);
        applyStimulus(32'h80000000, 0, 1'b0, extTmp);
        checkOutput("negzero_ext_const", extTmp, 33'h1_0000_0000);
        applyStimulus(32'h7F800000, 0, 1'b0, extTmp);
        checkOutput("inf_ext_const", extTmp, 33'h0_E000_0000);
        applyStimulus(32'h00400000, 1, 1'b0, extSubA);
        checkOutput("sub_a_ext_const", extSubA, 33'h0_4080_0000);
        applyStimulus(32'h00000001, 0, 1'b0, extSubB);
        checkOutput("sub_b_ext_const", extSubB, 33'h0_3580_0000);
        applyStimulus(32'h00800000, 0, 1'b0, extMin);
        checkOutput("minnorm_ext_const", extMin, 33'h0_4100_0000);
        checkOutput("order_sub_a", 33'(extSubA[31:0] < extMin[31:0]), 33'd1);
        checkOutput("order_sub_b", 33'(extSubB[31:0] < extSubA[31:0]), 33'd1);
        applyStimulus(32'h7F800001, 0, 1'b0, extTmp);
        applyStimulus(32'h7FC00000, 0, 1'b0, extTmp);
        applyStimulus(32'h7F7FFFFF, 0, 1'b0, extTmp);
        applyStimulus(32'h807FFFFF, 2, 1'b0, extTmp);

        // Backpressure with a decoy operand that must be taken only after release.
        applyStimulus(32'h40000000, 5, 1'b1, extTmp);
        applyStimulus(32'h40490FDB, 0, 1'b0, extTmp);

        // Asynchronous reset while normalizing the smallest subnormal.
        in_valid = 1'b1;
        in_data  = 32'h00000001;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (5) @(negedge clock);
        checkOutput("norm_busy", 33'(in_ready), 33'd0);
        #2 reset = 1'b0;
        #1;
        checkOutput("areset_out_valid", 33'(out_valid), 33'd0);
        checkOutput("areset_in_ready", 33'(in_ready), 33'd1);
        checkOutput("areset_out_ext", out_ext, 33'd0);
        checkOutput("areset_out_class", 33'(out_class), 33'd0);
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(32'h3F800000, 0, 1'b0, extTmp);

        for (int i = 0; i < 40; i++) begin
            cat = $urandom_range(0, 4);
            d   = $urandom;
            case (cat)
                1: begin
                    m = 23'($urandom) >> $urandom_range(0, 22);
                    if (m == 23'd0) m = 23'd1;
                    d = {d[31], 8'h00, m};
                end
                2: d = {d[31], 31'd0};
                3: d = {d[31], 8'hFF, ($urandom_range(0, 1) == 0) ? 23'd0 : d[22:0]};
                4: d = {d[31], (d[30:23] == 8'hFF) ? 8'h01 : d[30:23], d[22:0]};
                default: ;
            endcase
            applyStimulus(d, $urandom_range(0, 3), 1'($urandom_range(0, 1)), extTmp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule

// File: doc/fp_unpack.md
Name: fp_unpack

Overview:
- Front-end unpacker for the single-precision FPU.
- Converts a raw IEEE-754 binary32 operand into the 33-bit monotonic extended form and the 10-bit RISC-V fclass vector that min/max, compare and arithmetic units consume.
- Subnormals are normalized iteratively, one bit per cycle. All other classes complete in one cycle.
- Sits between the operand register read and the FP execution units, with a valid/ready handshake on both sides.

Parameters:
- none: format is fixed to binary32.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  unpacker can accept an operand.
- in_data  in  32  raw binary32 operand.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  32  in_data passed through unchanged.
- out_ext  out  33  extended operand: [32] sign, [31:23] exponent e9, [22:0] fraction.
- out_class  out  10  one-hot fclass vector.

Behaviour:
- Reset state:
  - State IDLE.
  - in_ready=1, out_valid=0.
  - out_data, out_ext, out_class, internal mantissa and lz counter all 0.
- Field split: s=in_data[31], E=in_data[30:23], M=in_data[22:0].
- Extended encoding (unsigned compare of ext[31:0] orders magnitudes):
  - Zero (E=0, M=0): e9=0, frac=0.
  - Normal (E 1..254): e9=E+129, frac=M.
  - Subnormal (E=0, M!=0): e9=129-lz, where lz = number of leading zeros of M (0..22); frac=M shifted left (lz+1) within 23 bits, hidden one dropped.
  - Inf/NaN (E=255): e9=9'h1C0, frac=M.
  - In every case ext[32]=s.
- fclass bit meanings:
  - 0 -inf, 1 -normal, 2 -subnormal, 3 -0, 4 +0
  - 5 +subnormal, 6 +normal, 7 +inf
  - 8 sNaN (E=255, M!=0, M[22]=0), 9 qNaN (E=255, M[22]=1)
  - NaN class bits ignore sign.
- States:
  - IDLE: in_ready=1.
    - On in_valid & in_ready, capture in_data.
    - Non-subnormal: compute ext/class, go DONE.
    - Subnormal: load mantissa register with M, clear lz, go NORM.
  - NORM: in_ready=0, out_valid=0.
    - If mant[22]=1: ext frac={mant[21:0],0}, e9=129-lz, class set, go DONE.
    - Else: mant<<=1, lz+=1, stay in NORM.
    - lz never exceeds 22.
  - DONE: out_valid=1, outputs stable.
    - On out_ready, go IDLE.
    - Otherwise hold all outputs unchanged for any number of cycles.
- Latency (accept edge to out_valid):
  - Non-subnormal: 1 cycle.
  - Subnormal: lz+2 cycles, maximum 24.
- Throughput: one operand in flight. in_ready=0 in NORM and DONE. No same-cycle accept on the out_ready handshake; the next accept is earliest the cycle after return to IDLE.
- in_valid while not ready: ignored, not captured.
- in_data changing while in NORM or DONE: no effect on the pending result.
- Reset asserted mid-NORM or DONE: operand discarded immediately (async); return to reset state.
- No exceptions raised. NaN signalling is left to consumers via class[8].

Test Plan:
- 1.0 (in_data=32'h3F800000) -> 1 cycle later: out_valid=1, out_ext=33'h0_8000_0000, out_class=10'h040, out_data=32'h3F800000.
- -0 (32'h80000000) -> out_ext=33'h1_0000_0000, out_class=10'h008, latency 1. +Inf (32'h7F800000) -> out_ext=33'h0_E000_0000, out_class=10'h080.
- Subnormal 32'h00400000 -> out_valid 2 cycles after accept, out_ext=33'h0_4080_0000, out_class=10'h020. Subnormal 32'h00000001 -> out_valid 24 cycles after accept, out_ext=33'h0_3580_0000. In both cases in_ready=0 throughout. Ordering check: each is below smallest normal 32'h00800000 (out_ext=33'h0_4100_0000).
- sNaN 32'h7F800001 -> out_class=10'h100, out_ext=33'h0_E000_0001. qNaN 32'h7FC00000 -> out_class=10'h200, out_ext=33'h0_E040_0000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs constant and in_ready=0. A second in_valid during this time is not taken. out_ready=1 -> in_ready=1 next cycle and the second operand is accepted.
- Assert reset during NORM of 32'h00000001 -> out_valid=0 and in_ready=1 immediately. After release, a new operand (1.0) completes with correct values in 1 cycle.
